// File: rtl/rat_ckpt_pkg.sv
// rat_ckpt_pkg: shared constants, types and field helpers for the RAT checkpoint buffer
package rat_ckpt_pkg;
    localparam int NUM_REGS = 32;
    localparam int TAG_W = 3;
    localparam int FIELD_W = TAG_W + 1;
    localparam int VEC_W = NUM_REGS * FIELD_W;
    typedef logic [VEC_W-1:0] rat_vec_t;
    typedef logic [FIELD_W-1:0] field_t;
    function automatic logic busy_of(input field_t f);
        return f[TAG_W];
    endfunction
    function automatic logic [TAG_W-1:0] tag_of(input field_t f);
        return f[TAG_W-1:0];
    endfunction
    function automatic field_t pack_field(input logic busy, input logic [TAG_W-1:0] tag);
        return {busy, tag};
    endfunction
    function automatic rat_vec_t clear_tag(input rat_vec_t vec, input logic [TAG_W-1:0] idx);
        rat_vec_t r;
        r = vec;
        for (int i = 0; i < NUM_REGS; i++)
            if (busy_of(vec[i*FIELD_W +: FIELD_W]) && tag_of(vec[i*FIELD_W +: FIELD_W]) == idx)
                r[i*FIELD_W + TAG_W] = 1'b0;
        return r;
    endfunction
endpackage

// File: rtl/rat_checkpoint_buf_slot.sv
// ckpt_slot: one checkpoint entry (valid, owner ROB index, snapshot) with commit-clear and owner CAM
//   wr_en/wr_owner/wr_vec: capture a snapshot (wr_vec already commit-cleared by the caller)
//   clr_en/clr_idx: commit-clear of busy fields tagged clr_idx
//   free_en: release on correct branch commit; flush: invalidate on mispredict
//   query/hit: owner compare; valid/snap: current state
module ckpt_slot
    import rat_ckpt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_owner,
    input  rat_vec_t         wr_vec,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_idx,
    input  logic             free_en,
    input  logic             flush,
    input  logic [TAG_W-1:0] query,
    output logic             valid,
    output logic             hit,
    output rat_vec_t         snap
);
    logic [TAG_W-1:0] owner;

    assign hit = valid && owner == query;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            owner <= '0;
            snap  <= '0;
        end else begin
            if (flush) valid <= 1'b0;
            else if (wr_en) valid <= 1'b1;
            else if (free_en) valid <= 1'b0;
            if (wr_en) owner <= wr_owner;
            if (wr_en) snap <= wr_vec;
            else if (clr_en) snap <= clear_tag(snap, clr_idx);
        end
    end
endmodule

// File: rtl/rat_checkpoint_buf.sv
// rat_checkpoint_buf: RAT tag snapshots per in-flight branch, restored to tregs on mispredict commit
//   alloc_valid/alloc_rob_idx/rat_tags_bus: branch dispatch snapshot request; alloc_ready: a slot is free
//   commit_*: ROB commit port; restore_valid/restore_tags/restore_miss: one-cycle restore response
//   ckpt_count: occupied slots
module rat_checkpoint_buf
    import rat_ckpt_pkg::*;
#(
    parameter int NUM_CKPT = 4,
    localparam int CNT_W = $clog2(NUM_CKPT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_valid,
    input  logic [TAG_W-1:0]            alloc_rob_idx,
    output logic                        alloc_ready,
    input  logic [NUM_REGS*FIELD_W-1:0] rat_tags_bus,
    input  logic                        commit_valid,
    input  logic [TAG_W-1:0]            commit_index,
    input  logic                        commit_is_branch,
    input  logic                        commit_mispredict,
    output logic                        restore_valid,
    output logic [NUM_REGS*FIELD_W-1:0] restore_tags,
    output logic                        restore_miss,
    output logic [CNT_W-1:0]            ckpt_count
);
    logic [NUM_CKPT-1:0] valid, hit, wr_sel, hit_sel;
    rat_vec_t snap [NUM_CKPT];
    rat_vec_t hit_vec, wr_vec;
    logic mispredict, good_branch, do_alloc, any_hit;

    assign mispredict  = commit_valid && commit_mispredict;
    assign good_branch = commit_valid && commit_is_branch && !commit_mispredict;
    assign alloc_ready = !(&valid);
    assign do_alloc    = alloc_valid && alloc_ready && !mispredict;
    assign wr_vec      = commit_valid ? clear_tag(rat_tags_bus, commit_index) : rat_tags_bus;
    assign any_hit     = |hit;

    // Walking down from the top lets the lowest free slot / lowest hit win.
    always_comb begin
        wr_sel = '0;
        hit_sel = '0;
        hit_vec = '0;
        ckpt_count = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                wr_sel = '0;
                wr_sel[i] = 1'b1;
            end
            if (hit[i]) begin
                hit_sel = '0;
                hit_sel[i] = 1'b1;
                hit_vec = snap[i];
            end
            ckpt_count = ckpt_count + CNT_W'(valid[i]);
        end
    end

    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
        ckpt_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (do_alloc && wr_sel[g]),
            .wr_owner (alloc_rob_idx),
            .wr_vec   (wr_vec),
            .clr_en   (commit_valid),
            .clr_idx  (commit_index),
            .free_en  (good_branch && hit_sel[g]),
            .flush    (mispredict),
            .query    (commit_index),
            .valid    (valid[g]),
            .hit      (hit[g]),
            .snap     (snap[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            restore_valid <= 1'b0;
            restore_miss  <= 1'b0;
            restore_tags  <= '0;
        end else begin
            restore_valid <= mispredict;
            restore_miss  <= mispredict && !any_hit;
            if (mispredict) restore_tags <= any_hit ? clear_tag(hit_vec, commit_index) : '0;
        end
    end

    a_alloc_when_full: assert property (@(posedge clk) disable iff (!rst) alloc_valid |-> alloc_ready)
        else $error("alloc_valid while no checkpoint slot is free");
    a_dup_owner: assert property (@(posedge clk) disable iff (!rst) commit_valid |-> $onehot0(hit))
        else $error("multiple checkpoint slots own the committed ROB index");
endmodule

// File: doc/rat_checkpoint_buf.md
Name: rat_checkpoint_buf

Overview:
- Captures register-alias-table (RAT) tag snapshots when a branch is dispatched.
- Keeps each snapshot current as ROB entries commit.
- On a mispredicted branch commit from the ROB, returns the matching snapshot as the restore vector for the register status table (tregs).
- Sits between dispatch, the ROB commit port and tregs; it is the consumer/responder side of the ROB mispredict-commit restore path.

Parameters:
- NUM_REGS, 32, architectural registers per snapshot.
- TAG_W, 3, ROB index width (ROB depth 2**TAG_W).
- NUM_CKPT, 4, checkpoint slots (maximum in-flight branches).
- FIELD_W, TAG_W+1, per-register field: bit TAG_W is busy, bits TAG_W-1:0 are the ROB tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  branch dispatched this cycle; take a snapshot.
- alloc_rob_idx  in  TAG_W  ROB index of the dispatched branch.
- alloc_ready  out  1  at least one free slot (registered state only).
- rat_tags_bus  in  NUM_REGS*FIELD_W  current tregs all_tags_bus, pre-update value this cycle.
- commit_valid  in  1  ROB commits one entry.
- commit_index  in  TAG_W  committed ROB index.
- commit_is_branch  in  1  committed entry owns a checkpoint.
- commit_mispredict  in  1  committed branch mispredicted.
- restore_valid  out  1  one-cycle pulse; restore_tags valid.
- restore_tags  out  NUM_REGS*FIELD_W  restored RAT tag vector.
- restore_miss  out  1  with restore_valid: no slot matched commit_index.
- ckpt_count  out  $clog2(NUM_CKPT+1)  occupied slots.

Behaviour:
- Reset (rst=0, async):
  - All slots invalid.
  - restore_valid=0, restore_miss=0, restore_tags=0, ckpt_count=0, alloc_ready=1.
- Slot state: valid bit, owner rob_idx, snapshot vector.
- Allocate:
  - Condition: alloc_valid && alloc_ready && !(commit_valid && commit_mispredict).
  - Target is the lowest-numbered free slot.
  - Write rat_tags_bus with commit-clear applied, owner = alloc_rob_idx.
  - alloc_valid while alloc_ready=0 is ignored; dispatch must not do this, and an assertion flags it.
- Commit-clear, every cycle with commit_valid:
  - For every valid slot and every register field with busy=1 and tag==commit_index, clear busy (tag retained).
  - The same clear applies to an incoming allocation snapshot in the same cycle.
- Correct branch commit (commit_valid && commit_is_branch && !commit_mispredict):
  - Free the slot whose owner==commit_index.
  - A slot freed this cycle is not reusable until the next cycle; alloc_ready has no bypass.
- Mispredict commit (commit_valid && commit_mispredict):
  - Cycle N: CAM owner==commit_index.
  - Cycle N+1:
    - restore_valid=1.
    - restore_tags = matched snapshot with the cycle-N commit-clear applied.
    - restore_miss=0.
  - If no slot matches: restore_tags = all zero (all registers not busy), restore_miss=1.
  - Also in cycle N: invalidate all slots (younger branches are flushed) and drop any same-cycle allocation.
- Output timing: restore_valid is high for exactly one cycle per mispredict; in all other cycles restore_valid=0 and restore_tags holds its last value.
- Duplicate owners: a CAM with more than one hit is illegal; an assertion flags it and the lowest slot wins.
- Occupancy: ckpt_count = popcount(valid), registered.
- Timing: single-cycle CAM plus clear; no internal pipelining beyond the one-cycle restore register.

Decomposition:
- Shared package rat_ckpt_pkg:
  - Constants NUM_REGS, TAG_W, FIELD_W.
  - Field-extract/pack functions (busy_of, tag_of).
  - Function clear_tag(vec, idx), used by both the top level and the slot.
- Sub-module ckpt_slot, instantiated NUM_CKPT times:
  - Holds valid/owner/snapshot.
  - Applies commit-clear.
  - Outputs hit = valid && owner==query.
- Top level: free-slot priority encoder, hit mux, restore register, counter.

Test Plan:
- Reset mid-operation: fill 3 slots, drop rst for 1 ns -> ckpt_count=0, alloc_ready=1, restore_valid=0 immediately, without waiting for a clock.
- Snapshot/restore: r5=busy tag 2, alloc rob 4, mispredict commit index 4 -> next cycle restore_valid=1, r5 field=4'b1010, restore_miss=0, ckpt_count=0.
- Commit-clear while held: alloc rob 4 with r5 tag 2 busy, commit index 2, then mispredict 4 -> r5 field=4'b0010 (not busy).
- Full/free: allocate rob 1,2,3,5 -> alloc_ready=0. Correct commit of rob 1 -> alloc_ready=1 next cycle, not the same cycle.
- Simultaneous alloc and mispredict: alloc rob 6 in the same cycle as mispredict of rob 3 -> slot not taken, ckpt_count=0 after, restore carries rob 3 snapshot.
- Miss: mispredict commit index 7 with no owner -> restore_valid=1, restore_miss=1, restore_tags=0.
